// File: rtl/ps2_line_buffer_if.sv
// Keystroke input and byte-stream output bundle for ps2_line_buffer.
// PS2_LINE_ECHO_EN adds the local-echo signals.
interface ps2_line_buffer_if;
    logic       new_code;
    logic [7:0] ascii_code;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       line_pending;
    logic       dropped;
`ifdef PS2_LINE_ECHO_EN
    logic       echo_valid;
    logic [7:0] echo_data;

    modport master (
        input  new_code, ascii_code, out_ready,
        output out_valid, out_data, out_last, line_pending, dropped,
        output echo_valid, echo_data
    );
    modport slave (
        output new_code, ascii_code, out_ready,
        input  out_valid, out_data, out_last, line_pending, dropped,
        input  echo_valid, echo_data
    );
`else
    modport master (
        input  new_code, ascii_code, out_ready,
        output out_valid, out_data, out_last, line_pending, dropped
    );
    modport slave (
        output new_code, ascii_code, out_ready,
        input  out_valid, out_data, out_last, line_pending, dropped
    );
`endif
endinterface

// File: rtl/ps2_line_buffer.sv
// Assembles ASCII keystrokes into an editable line and drains it on CR over valid/ready.
// Optional local echo of accepted edits: define PS2_LINE_ECHO_EN.
module ps2_line_buffer #(
    parameter int DEPTH_BITS = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    ps2_line_buffer_if.master  bus
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS-1:0] LAST_SLOT = DEPTH_BITS'(DEPTH - 1);
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] CR = 8'h0D;

    typedef enum logic {EDIT, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [DEPTH_BITS-1:0] count_q, count_d;
    logic [DEPTH_BITS-1:0] rd_idx_q, rd_idx_d;
    logic                  dropped_q, dropped_d;
    logic [7:0]            mem_q [DEPTH];
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  last_w;
`ifdef PS2_LINE_ECHO_EN
    logic                  echo_valid_q, echo_valid_d;
    logic [7:0]            echo_data_q, echo_data_d;
`endif

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    assign last_w           = (state_q == DRAIN) && (rd_idx_q == count_q);
    assign bus.out_valid    = (state_q == DRAIN);
    assign bus.line_pending = (state_q == DRAIN);
    assign bus.out_last     = last_w;
    assign bus.out_data     = mem_q[rd_idx_q];
    assign bus.dropped      = dropped_q;
`ifdef PS2_LINE_ECHO_EN
    assign bus.echo_valid   = echo_valid_q;
    assign bus.echo_data    = echo_data_q;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_idx_d  = rd_idx_q;
        dropped_d = 1'b0;
        wr_en     = 1'b0;
        wr_data   = bus.ascii_code;
`ifdef PS2_LINE_ECHO_EN
        echo_valid_d = 1'b0;
        echo_data_d  = echo_data_q;
`endif
        unique case (state_q)
            EDIT: begin
                if (bus.new_code) begin
                    if (is_printable(bus.ascii_code)) begin
                        // The top slot is held back so a CR can always terminate the line.
                        if (count_q != LAST_SLOT) begin
                            wr_en   = 1'b1;
                            count_d = count_q + 1'b1;
`ifdef PS2_LINE_ECHO_EN
                            echo_valid_d = 1'b1;
                            echo_data_d  = bus.ascii_code;
`endif
                        end else begin
                            dropped_d = 1'b1;
                        end
                    end else if (bus.ascii_code == BS) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
`ifdef PS2_LINE_ECHO_EN
                            echo_valid_d = 1'b1;
                            echo_data_d  = BS;
`endif
                        end
                    end else if (bus.ascii_code == CR) begin
                        wr_en    = 1'b1;
                        wr_data  = CR;
                        rd_idx_d = '0;
                        state_d  = DRAIN;
`ifdef PS2_LINE_ECHO_EN
                        echo_valid_d = 1'b1;
                        echo_data_d  = CR;
`endif
                    end
                end
            end
            DRAIN: begin
                dropped_d = bus.new_code;
                if (bus.out_ready) begin
                    if (last_w) begin
                        count_d  = '0;
                        rd_idx_d = '0;
                        state_d  = EDIT;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EDIT;
            count_q   <= '0;
            rd_idx_q  <= '0;
            dropped_q <= 1'b0;
`ifdef PS2_LINE_ECHO_EN
            echo_valid_q <= 1'b0;
            echo_data_q  <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_idx_q  <= rd_idx_d;
            dropped_q <= dropped_d;
`ifdef PS2_LINE_ECHO_EN
            echo_valid_q <= echo_valid_d;
            echo_data_q  <= echo_data_d;
`endif
        end
    end

    // Line storage carries no reset; only count_q decides which bytes are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q] <= wr_data;
        end
    end
endmodule

// File: tb/tb_ps2_line_buffer.sv
// Directed and random stimulus for ps2_line_buffer against a queue-based line model.
// Echo checks are compiled in when PS2_LINE_ECHO_EN is defined.
module tb_ps2_line_buffer;
    localparam int DB    = 3;
    localparam int DEPTH = 1 << DB;

    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    ps2_line_buffer_if bus ();

    ps2_line_buffer #(.DEPTH_BITS(DB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: the line being edited and the expected drain stream.
    logic [7:0] line_q [$];
    logic [7:0] drain_q [$];
    bit         m_drain = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit e_drop, input bit e_echo, input logic [7:0] e_ed);
        chk("out_valid", {7'd0, bus.out_valid}, {7'd0, m_drain});
        chk("line_pending", {7'd0, bus.line_pending}, {7'd0, m_drain});
        chk("dropped", {7'd0, bus.dropped}, {7'd0, e_drop});
        if (m_drain) begin
            chk("out_data", bus.out_data, drain_q[0]);
            chk("out_last", {7'd0, bus.out_last}, {7'd0, drain_q.size() == 1});
        end
`ifdef PS2_LINE_ECHO_EN
        chk("echo_valid", {7'd0, bus.echo_valid}, {7'd0, e_echo});
        if (e_echo) chk("echo_data", bus.echo_data, e_ed);
`endif
    endtask

    task automatic step(input bit nc, input logic [7:0] code, input bit rdy);
        bit         e_drop = 1'b0;
        bit         e_echo = 1'b0;
        logic [7:0] e_ed   = 8'h00;
        bus.new_code   = nc;
        bus.ascii_code = code;
        bus.out_ready  = rdy;
        if (!m_drain) begin
            if (nc) begin
                if (code >= 8'h20 && code <= 8'h7E) begin
                    if (line_q.size() < DEPTH - 1) begin
                        line_q.push_back(code);
                        e_echo = 1'b1; e_ed = code;
                    end else begin
                        e_drop = 1'b1;
                    end
                end else if (code == 8'h08) begin
                    if (line_q.size() > 0) begin
                        void'(line_q.pop_back());
                        e_echo = 1'b1; e_ed = code;
                    end
                end else if (code == 8'h0D) begin
                    drain_q = line_q;
                    drain_q.push_back(8'h0D);
                    line_q.delete();
                    m_drain = 1'b1;
                    e_echo = 1'b1; e_ed = code;
                end
            end
        end else begin
            e_drop = nc;
            if (rdy) begin
                void'(drain_q.pop_front());
                if (drain_q.size() == 0) m_drain = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.new_code = 1'b0;
        check_outputs(e_drop, e_echo, e_ed);
    endtask

    task automatic key(input logic [7:0] code);
        step(1'b1, code, 1'b1);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 8'h00, rdy);
    endtask

    task automatic flush();
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    endtask

    task automatic model_reset();
        line_q.delete();
        drain_q.delete();
        m_drain = 1'b0;
    endtask

    initial begin
        logic [7:0] others [6];
        others = '{8'h00, 8'h01, 8'h1B, 8'h7F, 8'h80, 8'hFF};

        reset_n        = 1'b0;
        bus.new_code   = 1'b0;
        bus.ascii_code = 8'h00;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("rst_out_last", {7'd0, bus.out_last}, 8'd0);
        chk("rst_line_pending", {7'd0, bus.line_pending}, 8'd0);
        chk("rst_dropped", {7'd0, bus.dropped}, 8'd0);
`ifdef PS2_LINE_ECHO_EN
        chk("rst_echo_valid", {7'd0, bus.echo_valid}, 8'd0);
        chk("rst_echo_data", bus.echo_data, 8'd0);
`endif
        reset_n = 1'b1;
        idle(1'b1);

        // Simple line drained at full rate.
        key(8'h41); key(8'h42); key(8'h0D);
        flush();

        // Leading backspace on empty line, then edit with backspace.
        key(8'h08);
        key(8'h41); key(8'h58); key(8'h08); key(8'h42); key(8'h0D);
        flush();

        // Fill past capacity: eighth printable is dropped.
        for (int i = 0; i < DEPTH; i++) key(8'h61 + 8'(i));
        key(8'h0D);
        flush();

        // Empty line.
        key(8'h0D);
        flush();

        // Back-pressure and a strobe during drain.
        key(8'h41); key(8'h42); key(8'h0D);
        for (int i = 0; i < 5; i++) idle(1'b0);
        step(1'b1, 8'h43, 1'b0);
        step(1'b1, 8'h43, 1'b1);
        idle(1'b1);
        step(1'b1, 8'h43, 1'b1);
        flush();

        // Echo pattern including an ignored control code.
        key(8'h41); key(8'h01); key(8'h08); key(8'h0D);
        flush();

        // Reset during drain after the first byte is taken.
        key(8'h41); key(8'h42); key(8'h0D);
        idle(1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        chk("midrst_line_pending", {7'd0, bus.line_pending}, 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1'b1);
        key(8'h5A); key(8'h0D);
        flush();

        // Random keystrokes and back-pressure.
        for (int n = 0; n < 3000; n++) begin
            int         sel;
            logic [7:0] code;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      code = 8'($urandom_range(32, 126));
            else if (sel == 6) code = 8'h08;
            else if (sel == 7) code = 8'h0D;
            else               code = others[$urandom_range(0, 5)];
            step($urandom_range(0, 2) != 0, code, $urandom_range(0, 3) != 0);
        end
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
